// File: rtl/fxp_pkg.sv
// Shared types and constants for the fixed-point divider.
// FXP_DIV_ROUND_EN adds a guard iteration for round-half-away-from-zero.
package fxp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t DONE = 2'd2;

  function automatic int iter_f(input int nbits, input int nbitsf);
`ifdef FXP_DIV_ROUND_EN
    return nbits + nbitsf + 1;
`else
    return nbits + nbitsf;
`endif
  endfunction

  function automatic int maxp_f(input int nbits);
    return (1 << (nbits - 1)) - 1;
  endfunction

  function automatic int maxn_f(input int nbits);
    return 1 << (nbits - 1);
  endfunction

endpackage

// File: rtl/fxp_div_step.sv
// One restoring shift-subtract step of the divider.
// Produces the next remainder and one quotient bit.
module fxp_div_step #(
  parameter int RW = 9
) (
  input  logic [RW-1:0] rem,
  input  logic [RW-1:0] dvs,
  input  logic          bin,
  output logic [RW-1:0] rem_nx,
  output logic          qbit
);

  logic [RW:0] sh;
  logic [RW:0] dx;

  always_comb begin
    sh     = {rem, bin};
    dx     = {1'b0, dvs};
    qbit   = (sh >= dx);
    rem_nx = qbit ? RW'(sh - dx) : RW'(sh);
  end

endmodule

// File: rtl/fxp_div.sv
// Sequential signed Q(NBITSI).(NBITSF) divider, one quotient bit per cycle.
// Define FXP_DIV_ROUND_EN for rounding instead of truncation.
module fxp_div
  import fxp_pkg::*;
#(
  parameter int NBITS  = 8,
  parameter int NBITSI = 6,
  parameter int NBITSF = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] div_inA,
  input  logic [NBITS-1:0] div_inB,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [NBITS-1:0] div_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             div_zero,
  output logic             div_sat
);

  localparam int ITER = iter_f(NBITS, NBITSF);
  localparam int RW   = NBITS + 1;
  localparam int MW   = NBITS + NBITSF + 1;
  localparam int CW   = $clog2(ITER + 1);
  localparam int PAD  = ITER - NBITS;
  localparam int MAXP = maxp_f(NBITS);
  localparam int MAXN = maxn_f(NBITS);

  if (NBITSI + NBITSF != NBITS) begin : g_bad_fmt
    $error("fxp_div: NBITSI + NBITSF must equal NBITS");
  end

  state_t          st;
  logic            sgn;
  logic            zdiv;
  logic            fin;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   rem;
  logic [RW-1:0]   dvs;
  logic [ITER-1:0] dvd;
  logic [ITER-1:0] quo;

  logic [NBITS-1:0] mag_a;
  logic [NBITS-1:0] mag_b;
  logic [RW-1:0]    rem_nx;
  logic             qbit;

  // Unsigned NBITS magnitude is exact even for the most negative operand
  always_comb begin
    mag_a = div_inA[NBITS-1] ? -div_inA : div_inA;
    mag_b = div_inB[NBITS-1] ? -div_inB : div_inB;
  end

  fxp_div_step #(
    .RW(RW)
  ) u_step (
    .rem   (rem),
    .dvs   (dvs),
    .bin   (dvd[ITER-1]),
    .rem_nx(rem_nx),
    .qbit  (qbit)
  );

  logic [MW-1:0]    mag;
  logic [NBITS-1:0] lim;
  logic [NBITS-1:0] mcl;
  logic [NBITS-1:0] res;
  logic             sat;

  always_comb begin
`ifdef FXP_DIV_ROUND_EN
    mag = MW'(quo[ITER-1:1]) + MW'(quo[0]);
`else
    mag = MW'(quo);
`endif
    lim = sgn ? NBITS'(MAXN) : NBITS'(MAXP);
    sat = (mag > MW'(lim));
    mcl = (sat || zdiv) ? lim : mag[NBITS-1:0];
    res = sgn ? -mcl : mcl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      div_out   <= '0;
      div_zero  <= 1'b0;
      div_sat   <= 1'b0;
      sgn       <= 1'b0;
      zdiv      <= 1'b0;
      fin       <= 1'b0;
      cnt       <= '0;
      rem       <= '0;
      dvs       <= '0;
      dvd       <= '0;
      quo       <= '0;
    end else begin
      unique case (1'b1)
        (st == IDLE): begin
          if (in_valid) begin
            sgn      <= div_inA[NBITS-1] ^ div_inB[NBITS-1];
            zdiv     <= (div_inB == '0);
            dvs      <= {1'b0, mag_b};
            dvd      <= {mag_a, {PAD{1'b0}}};
            rem      <= '0;
            quo      <= '0;
            fin      <= 1'b0;
            cnt      <= CW'(ITER - 1);
            in_ready <= 1'b0;
            st       <= BUSY;
          end else begin
            in_ready <= 1'b1;
          end
        end
        (st == BUSY): begin
          if (!fin) begin
            rem <= rem_nx;
            quo <= {quo[ITER-2:0], qbit};
            dvd <= dvd << 1;
            if (cnt == '0) fin <= 1'b1;
            else cnt <= cnt - CW'(1);
          end else begin
            fin       <= 1'b0;
            div_out   <= res;
            div_zero  <= zdiv;
            div_sat   <= sat & ~zdiv;
            out_valid <= 1'b1;
            st        <= DONE;
          end
        end
        (st == DONE): begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            st        <= IDLE;
          end
        end
        default: begin
          st        <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_div.sv
// Directed self-checking bench for fxp_div.
// Honours FXP_DIV_ROUND_EN for latency and rounded results.
module tb_fxp_div;

`ifdef FXP_DIV_ROUND_EN
  localparam int LAT  = 12;
  localparam int Q812 = 3;
  localparam int QM72 = -4;
`else
  localparam int LAT  = 11;
  localparam int Q812 = 2;
  localparam int QM72 = -3;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] ina;
  logic [7:0] inb;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] div_out;
  logic       out_valid;
  logic       out_ready;
  logic       div_zero;
  logic       div_sat;

  int ncmp;
  int nbad;

  fxp_div #(
    .NBITS (8),
    .NBITSI(6),
    .NBITSF(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_inA  (ina),
    .div_inB  (inb),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .div_out  (div_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .div_zero (div_zero),
    .div_sat  (div_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic op(input string tag, input int a, input int b,
                    input int eq, input int ez, input int es,
                    input int hold);
    int n;
    logic [7:0] snap;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, int'(in_ready), 1);
    ina      = 8'(a);
    inb      = 8'(b);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, LAT);
    chk({tag, "_q"}, int'($signed(div_out)), eq);
    chk({tag, "_z"}, int'(div_zero), ez);
    chk({tag, "_s"}, int'(div_sat), es);
    snap = div_out;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hv"}, int'(out_valid), 1);
      chk({tag, "_hq"}, int'(div_out), int'(snap));
      chk({tag, "_hr"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    if (hold > 0) begin
      chk({tag, "_rel_rdy"}, int'(in_ready), 1);
      chk({tag, "_rel_v"}, int'(out_valid), 0);
    end
  endtask

  initial begin
    int seen;
    ncmp      = 0;
    nbad      = 0;
    rst_n     = 1'b0;
    ina       = '0;
    inb       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", int'(in_ready), 0);
    chk("rst_v", int'(out_valid), 0);
    chk("rst_q", int'(div_out), 0);
    chk("rst_zs", int'({div_zero, div_sat}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_rdy", int'(in_ready), 1);

    op("p6d2",    24,   8,   12, 0, 0, 0);
    op("m5d2",   -20,   8,  -10, 0, 0, 0);
    op("p2d3",     8,  12, Q812, 0, 0, 0);
    op("m7d2",    -7,   8, QM72, 0, 0, 0);
    op("mm",     -24,  -8,   12, 0, 0, 0);
    op("satp",   127,   1,  127, 0, 1, 0);
    op("satn",  -128,   1, -128, 0, 1, 0);
    op("zneg",   -12,   0, -128, 1, 0, 0);
    op("z00",      0,   0,  127, 1, 0, 0);
    op("nz",       0,  -8,    0, 0, 0, 0);
    op("bp",      24,   8,   12, 0, 0, 20);

    // Abort mid-computation with an asynchronous reset
    @(negedge clk);
    ina      = 8'd24;
    inb      = 8'd8;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abt_v", int'(out_valid), 0);
    chk("abt_q", int'(div_out), 0);
    chk("abt_rdy", int'(in_ready), 0);
    chk("abt_zs", int'({div_zero, div_sat}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    chk("abt_noout", seen, 0);

    op("post", 24, 8, 12, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
